// File: rtl/tileram_console.sv
// Character-stream front end for the 128x8 tile RAM write port: places printable
// codes at a row/column cursor, handles CR/LF/BS, and runs a full-screen BLANK fill.
module tileram_console #(
  parameter int          COLS  = 16,
  parameter int          ROWS  = 8,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clr_req,
  output logic       busy,
  output logic [6:0] ram_waddr,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  output logic [6:0] cursor
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [6:0] LAST = 7'(COLS * ROWS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [6:0]      r_cnt, w_cnt_nxt;
  logic            r_we, w_we_nxt;
  logic [6:0]      r_waddr, w_waddr_nxt;
  logic [7:0]      r_wdata, w_wdata_nxt;

  logic [6:0]      w_cursor;
  logic            w_col_last;
  logic            w_row_last;
  logic [RW-1:0]   w_row_inc;

  assign w_cursor   = 7'(int'(r_row) * COLS + int'(r_col));
  assign w_col_last = (r_col == CW'(COLS - 1));
  assign w_row_last = (r_row == RW'(ROWS - 1));
  assign w_row_inc  = w_row_last ? '0 : r_row + 1'b1;

  assign in_ready  = (r_state == S_IDLE) && !clr_req;
  assign busy      = (r_state == S_CLEAR);
  assign ram_we    = r_we;
  assign ram_waddr = r_waddr;
  assign ram_wdata = r_wdata;
  assign cursor    = w_cursor;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          // First clear write is issued on the request edge so the fill has no lead-in bubble.
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
          w_we_nxt    = 1'b1;
          w_waddr_nxt = '0;
          w_wdata_nxt = BLANK;
        end else if (in_valid) begin
          if (in_data >= 8'h20) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_cursor;
            w_wdata_nxt = in_data;
            if (w_col_last) begin
              w_col_nxt = '0;
              w_row_nxt = w_row_inc;
            end else begin
              w_col_nxt = r_col + 1'b1;
            end
          end else if (in_data == 8'h0D) begin
            w_col_nxt = '0;
          end else if (in_data == 8'h0A) begin
            w_col_nxt = '0;
            w_row_nxt = w_row_inc;
          end else if (in_data == 8'h08 && w_cursor != 7'd0) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_cursor - 7'd1;
            w_wdata_nxt = BLANK;
            if (r_col == '0) begin
              w_col_nxt = CW'(COLS - 1);
              w_row_nxt = r_row - 1'b1;
            end else begin
              w_col_nxt = r_col - 1'b1;
            end
          end
        end
      end
      S_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_IDLE;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 7'd1;
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_cnt + 7'd1;
          w_wdata_nxt = BLANK;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_tileram_console.sv
// Directed bench for tileram_console: cursor movement, control codes, clear and reset abort.
module tb_tileram_console;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       clr_req;
  logic       busy;
  logic [6:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [6:0] cursor;

  int errors = 0;
  int checks = 0;

  tileram_console #(.COLS(16), .ROWS(8), .BLANK(8'h20)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clr_req(clr_req), .busy(busy),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .cursor(cursor)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_char(input logic [7:0] c);
    in_valid = 1'b1;
    in_data  = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", ram_we); end
    checks++; if (ram_waddr !== 7'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", ram_waddr); end
    checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h exp=00", ram_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cursor !== 7'd0) begin errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1; in_data = 8'h41;
    @(negedge clk);
    in_data = 8'h42;
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 7'd0 || ram_wdata !== 8'h41) begin
      errors++; $display("FAIL b2b_A got we=%b addr=%0d data=%h exp we=1 addr=0 data=41", ram_we, ram_waddr, ram_wdata); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 7'd1 || ram_wdata !== 8'h42) begin
      errors++; $display("FAIL b2b_B got we=%b addr=%0d data=%h exp we=1 addr=1 data=42", ram_we, ram_waddr, ram_wdata); end
    @(negedge clk);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL b2b_we_drop got=%b exp=0", ram_we); end
    checks++; if (cursor !== 7'd2) begin errors++; $display("FAIL b2b_cursor got=%0d exp=2", cursor); end
  endtask

  task automatic test_cr_lf;
    for (int i = 0; i < 13; i++) send_char(8'h61);
    checks++; if (cursor !== 7'd15) begin errors++; $display("FAIL crlf_pre_cursor got=%0d exp=15", cursor); end
    send_char(8'h58);
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 7'd15 || ram_wdata !== 8'h58) begin
      errors++; $display("FAIL crlf_X got we=%b addr=%0d data=%h exp we=1 addr=15 data=58", ram_we, ram_waddr, ram_wdata); end
    checks++; if (cursor !== 7'd16) begin errors++; $display("FAIL crlf_X_cursor got=%0d exp=16", cursor); end
    send_char(8'h0D);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL crlf_CR_we got=%b exp=0", ram_we); end
    checks++; if (cursor !== 7'd16) begin errors++; $display("FAIL crlf_CR_cursor got=%0d exp=16", cursor); end
    send_char(8'h0A);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL crlf_LF_we got=%b exp=0", ram_we); end
    checks++; if (cursor !== 7'd32) begin errors++; $display("FAIL crlf_LF_cursor got=%0d exp=32", cursor); end
  endtask

  task automatic test_wrap_and_bs0;
    for (int i = 0; i < 5; i++) send_char(8'h0A);
    checks++; if (cursor !== 7'd112) begin errors++; $display("FAIL wrap_row7_cursor got=%0d exp=112", cursor); end
    for (int i = 0; i < 15; i++) send_char(8'h62);
    checks++; if (cursor !== 7'd127) begin errors++; $display("FAIL wrap_pre_cursor got=%0d exp=127", cursor); end
    send_char(8'h5A);
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 7'd127 || ram_wdata !== 8'h5A) begin
      errors++; $display("FAIL wrap_Z got we=%b addr=%0d data=%h exp we=1 addr=127 data=5a", ram_we, ram_waddr, ram_wdata); end
    checks++; if (cursor !== 7'd0) begin errors++; $display("FAIL wrap_cursor got=%0d exp=0", cursor); end
    send_char(8'h08);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL bs0_we got=%b exp=0", ram_we); end
    checks++; if (cursor !== 7'd0) begin errors++; $display("FAIL bs0_cursor got=%0d exp=0", cursor); end
  endtask

  task automatic test_bs_and_ignore;
    send_char(8'h0A);
    send_char(8'h63);
    checks++; if (cursor !== 7'd17) begin errors++; $display("FAIL bs_pre_cursor got=%0d exp=17", cursor); end
    send_char(8'h08);
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 7'd16 || ram_wdata !== 8'h20) begin
      errors++; $display("FAIL bs_write got we=%b addr=%0d data=%h exp we=1 addr=16 data=20", ram_we, ram_waddr, ram_wdata); end
    checks++; if (cursor !== 7'd16) begin errors++; $display("FAIL bs_cursor got=%0d exp=16", cursor); end
    in_valid = 1'b1; in_data = 8'h07;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bel_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL bel_we got=%b exp=0", ram_we); end
    checks++; if (cursor !== 7'd16) begin errors++; $display("FAIL bel_cursor got=%0d exp=16", cursor); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bel_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_clear;
    int bad;
    bad = 0;
    clr_req = 1'b1; in_valid = 1'b1; in_data = 8'h51;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_collide got=%b exp=0", in_ready); end
    @(negedge clk);
    clr_req = 1'b0;
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_waddr !== 7'(i) || ram_wdata !== 8'h20 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL clr_write_%0d got we=%b addr=%0d data=%h busy=%b rdy=%b exp we=1 addr=%0d data=20 busy=1 rdy=0",
                 i, ram_we, ram_waddr, ram_wdata, busy, in_ready, i);
      end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_done_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_done_ready got=%b exp=1", in_ready); end
    checks++; if (cursor !== 7'd0) begin errors++; $display("FAIL clr_done_cursor got=%0d exp=0", cursor); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL clr_done_we got=%b exp=0", ram_we); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 7'd0 || ram_wdata !== 8'h51) begin
      errors++; $display("FAIL clr_then_Q got we=%b addr=%0d data=%h exp we=1 addr=0 data=51", ram_we, ram_waddr, ram_wdata); end
    checks++; if (cursor !== 7'd1) begin errors++; $display("FAIL clr_then_Q_cursor got=%0d exp=1", cursor); end
  endtask

  task automatic test_reset_abort;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 7'd40) begin
      errors++; $display("FAIL abort_pre got we=%b addr=%0d exp we=1 addr=40", ram_we, ram_waddr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL abort_we got=%b exp=0", ram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (cursor !== 7'd0) begin errors++; $display("FAIL abort_cursor got=%0d exp=0", cursor); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL abort_quiet_%0d got we=%b exp=0", i, ram_we); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_req = 1'b0;
    @(negedge clk);
    test_reset;
    test_back_to_back;
    test_cr_lf;
    test_wrap_and_bs0;
    test_bs_and_ignore;
    test_clear;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
